sid_reg_sequencer: RTL and testbench

//  Schedules all register accesses to the sid core. Two sources share the bus: the CPU port, which always has

---
 rtl/sid_reg_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sid_reg_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_reg_sequencer.sv
// sid_reg_sequencer: shares the sid register bus between a CPU port (always
// first) and a small command FIFO of register writes and timed delays. At most
// one sid access is scheduled per ce tick; every access is a one-clk sid_cs
// pulse in the clk after the tick that granted it.
module sid_reg_sequencer #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          flush,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [4:0]    cpu_a,
  input  logic [7:0]    cpu_di,
  output logic [7:0]    cpu_do,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_delay,
  input  logic [4:0]    cmd_a,
  input  logic [7:0]    cmd_d,
  output logic          sid_cs,
  output logic          sid_rw,
  output logic [4:0]    sid_a,
  output logic [7:0]    sid_di,
  input  logic [7:0]    sid_do,
  output logic [LW-1:0] fifo_level,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 14;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Command storage: entry = {delay, addr[4:0], data[7:0]}
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          sid_cs_q, sid_rw_q;
  logic [4:0]    sid_a_q;
  logic [7:0]    sid_di_q;
  logic [7:0]    cpu_do_q;

  logic          full, empty, push, pop;
  logic          cpu_tick, pop_wr, pop_delay;
  logic          head_dly;
  logic [4:0]    head_a;
  logic [7:0]    head_d;

  // Scheduling decode: which access (if any) this clk grants
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == '0);
    // A full FIFO refuses a push even if it pops in the same clk; flush drops it
    push      = cmd_valid & ~full & ~flush;
    cpu_tick  = ce & cpu_cs;
    {head_dly, head_a, head_d} = mem_q[rd_ptr_q];
    pop       = ce & ~cpu_cs & ~flush & (state_q == S_IDLE) & ~empty;
    pop_wr    = pop & ~head_dly;
    // A zero-length delay is consumed as a no-op and never enters WAIT
    pop_delay = pop & head_dly & (head_d != 8'd0);
  end

  // Next-state logic for the delay countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else if (state_q == S_WAIT) begin
      // Countdown keeps running on ticks taken by the CPU port
      if (ce) begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
        end
      end
    end else if (pop_delay) begin
      state_d = S_WAIT;
      cnt_d   = head_d;
    end
  end

  // State and countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_delay, cmd_a, cmd_d};
    end
  end

  // sid access register: one-clk pulse, address/data/rw hold afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sid_cs_q <= 1'b0;
      sid_rw_q <= 1'b0;
      sid_a_q  <= 5'd0;
      sid_di_q <= 8'd0;
    end else begin
      sid_cs_q <= 1'b0;
      if (cpu_tick) begin
        sid_cs_q <= 1'b1;
        sid_rw_q <= cpu_we;
        sid_a_q  <= cpu_a;
        sid_di_q <= cpu_di;
      end else if (pop_wr) begin
        sid_cs_q <= 1'b1;
        sid_rw_q <= 1'b1;
        sid_a_q  <= head_a;
        sid_di_q <= head_d;
      end
    end
  end

  // CPU read capture; only the CPU port ever issues reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_do_q <= 8'd0;
    end else if (sid_cs_q && !sid_rw_q) begin
      cpu_do_q <= sid_do;
    end
  end

  // Output mapping
  always_comb begin
    sid_cs     = sid_cs_q;
    sid_rw     = sid_rw_q;
    sid_a      = sid_a_q;
    sid_di     = sid_di_q;
    cpu_do     = cpu_do_q;
    fifo_level = level_q;
    cmd_ready  = ~full;
    busy       = ~empty | (state_q == S_WAIT) | sid_cs_q;
  end

endmodule

// File: tb/tb_sid_reg_sequencer.sv
// Testbench for sid_reg_sequencer: directed scenarios followed by randomized
// traffic, all checked every clk against a queue-based reference model.
module tb_sid_reg_sequencer;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce, flush, cpu_cs, cpu_we;
  logic [4:0]    cpu_a;
  logic [7:0]    cpu_di, cpu_do;
  logic          cmd_valid, cmd_ready, cmd_delay;
  logic [4:0]    cmd_a;
  logic [7:0]    cmd_d;
  logic          sid_cs, sid_rw;
  logic [4:0]    sid_a;
  logic [7:0]    sid_di, sid_do;
  logic [LW-1:0] fifo_level;
  logic          busy;

  sid_reg_sequencer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di), .cpu_do(cpu_do),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_delay(cmd_delay),
    .cmd_a(cmd_a), .cmd_d(cmd_d),
    .sid_cs(sid_cs), .sid_rw(sid_rw), .sid_a(sid_a), .sid_di(sid_di), .sid_do(sid_do),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  // Simple sid register file answering reads while sid_cs is high
  logic [7:0] sid_regs [32];
  assign sid_do = sid_cs ? sid_regs[sid_a] : 8'h00;

  // Reference model: command queue plus the first tick index at which a pop is allowed
  typedef struct {
    bit       dly;
    bit [4:0] a;
    bit [7:0] d;
  } cmd_t;

  cmd_t     q[$];
  int       tk;
  int       next_pop;
  bit       m_cs, m_rw;
  bit [4:0] m_a;
  bit [7:0] m_di, m_do;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    check("sid_cs",     32'(sid_cs),     32'(m_cs));
    check("sid_rw",     32'(sid_rw),     32'(m_rw));
    check("sid_a",      32'(sid_a),      32'(m_a));
    check("sid_di",     32'(sid_di),     32'(m_di));
    check("cpu_do",     32'(cpu_do),     32'(m_do));
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("cmd_ready",  32'(cmd_ready),  32'(q.size() < DEPTH));
    check("busy",       32'(busy),       32'((q.size() != 0) || (tk < next_pop) || m_cs));
  endtask

  task automatic idle();
    ce = 1'b0; flush = 1'b0;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_a = 5'd0; cpu_di = 8'd0;
    cmd_valid = 1'b0; cmd_delay = 1'b0; cmd_a = 5'd0; cmd_d = 8'd0;
  endtask

  // Advance the model by one clk using the currently driven inputs, then compare
  task automatic step();
    cmd_t e;
    bit   n_cs;
    bit   was_full;
    n_cs     = 1'b0;
    was_full = (q.size() == DEPTH);
    if (m_cs && !m_rw) m_do = sid_regs[m_a];
    if (ce) begin
      if (cpu_cs) begin
        n_cs = 1'b1; m_rw = cpu_we; m_a = cpu_a; m_di = cpu_di;
      end else if (!flush && q.size() > 0 && tk >= next_pop) begin
        e = q.pop_front();
        if (!e.dly) begin
          n_cs = 1'b1; m_rw = 1'b1; m_a = e.a; m_di = e.d;
        end else if (e.d != 0) begin
          next_pop = tk + 1 + int'(e.d);
        end
      end
      tk++;
    end
    if (flush) begin
      q.delete();
      next_pop = 0;
    end else if (cmd_valid && !was_full) begin
      q.push_back(cmd_t'{cmd_delay, cmd_a, cmd_d});
    end
    m_cs = n_cs;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    q.delete();
    tk = 0; next_pop = 0;
    m_cs = 1'b0; m_rw = 1'b0; m_a = 5'd0; m_di = 8'd0; m_do = 8'd0;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input bit dly, input bit [4:0] a, input bit [7:0] d);
    idle();
    cmd_valid = 1'b1; cmd_delay = dly; cmd_a = a; cmd_d = d;
    step();
    idle();
  endtask

  task automatic tick();
    idle();
    ce = 1'b1;
    step();
    idle();
  endtask

  task automatic cpu(input bit we, input bit [4:0] a, input bit [7:0] d);
    idle();
    ce = 1'b1; cpu_cs = 1'b1; cpu_we = we; cpu_a = a; cpu_di = d;
    step();
    idle();
  endtask

  task automatic nop(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sid_regs[i] = 8'($urandom);
    sid_regs[5'h1b] = 8'h55;
    idle();
    do_reset();

    // T1 single write with ce every 4th clk
    push(1'b0, 5'h04, 8'h41);
    for (int i = 0; i < 12; i++) begin
      idle();
      ce = (i % 4 == 3);
      step();
    end

    // T2 CPU priority over queued writes
    push(1'b0, 5'h00, 8'h05);
    push(1'b0, 5'h01, 8'h24);
    cpu(1'b1, 5'h18, 8'h2f);
    tick();
    tick();
    nop(2);

    // T3 write, delay of 3 ticks, write; ce every clk
    push(1'b0, 5'h04, 8'h41);
    push(1'b1, 5'h00, 8'h03);
    push(1'b0, 5'h04, 8'h40);
    for (int i = 0; i < 8; i++) tick();

    // T4 fill beyond capacity with ce low, then one tick
    for (int i = 0; i < 5; i++) push(1'b0, 5'(i), 8'(8'h10 + i));
    tick();
    for (int i = 0; i < 5; i++) tick();

    // T5 CPU read, then a sequencer write must not disturb cpu_do
    cpu(1'b0, 5'h1b, 8'h00);
    nop(2);
    push(1'b0, 5'h02, 8'h77);
    tick();
    nop(2);

    // T6a reset mid-WAIT with entries queued, right as a pulse is high
    push(1'b1, 5'h00, 8'h06);
    push(1'b0, 5'h05, 8'h01);
    push(1'b0, 5'h06, 8'h02);
    push(1'b0, 5'h07, 8'h03);
    tick();
    cpu(1'b1, 5'h09, 8'h99);
    do_reset();
    for (int i = 0; i < 8; i++) tick();

    // T6b flush in the same state, with a simultaneous push and CPU tick
    push(1'b1, 5'h00, 8'h06);
    push(1'b0, 5'h05, 8'h01);
    push(1'b0, 5'h06, 8'h02);
    push(1'b0, 5'h07, 8'h03);
    tick();
    idle();
    flush = 1'b1; ce = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_a = 5'h0a; cpu_di = 8'h3c;
    cmd_valid = 1'b1; cmd_a = 5'h0b; cmd_d = 8'h11;
    step();
    for (int i = 0; i < 8; i++) tick();

    // Zero-length delay is a no-op
    push(1'b1, 5'h00, 8'h00);
    push(1'b0, 5'h03, 8'h33);
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic; first half ce every clk, second half sparse ce
    for (int i = 0; i < 3000; i++) begin
      idle();
      ce        = (i < 1500) ? 1'b1 : ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      cpu_cs    = ($urandom_range(0, 5) == 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_a     = 5'($urandom);
      cpu_di    = 8'($urandom);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_delay = ($urandom_range(0, 3) == 0);
      cmd_a     = 5'($urandom);
      cmd_d     = cmd_delay ? 8'($urandom_range(0, 5)) : 8'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end

    idle();
    nop(4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
